// File: rtl/button_conditioner_if.sv
// Pin-side bundle of the button conditioner: raw button levels in,
// debounced levels and enable pulses out.
interface button_conditioner_if #(
    parameter int N_BTN = 6
);
    logic [N_BTN-1:0] PB_in;
    logic [N_BTN-1:0] DPB;
    logic [N_BTN-1:0] SCEN;
    logic [N_BTN-1:0] MCEN;

    // The button side drives raw levels; the conditioner drives levels and pulses.
    modport master (output PB_in, input DPB, SCEN, MCEN);
    modport slave  (input PB_in, output DPB, SCEN, MCEN);
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchronizer, debounce FSM, single-press pulse (SCEN) and
// auto-repeat pulse train (MCEN) for the memory-game push-buttons.
module button_conditioner #(
    parameter int N_BTN      = 6,
    parameter int DB_CNT     = 1000000,
    parameter int HOLD_CNT   = 50000000,
    parameter int REPEAT_CNT = 10000000,
    parameter int CNT_W      = 27
) (
    input  logic                 Clk,
    input  logic                 Reset,
    button_conditioner_if.slave  btn,
    output logic [3*N_BTN-1:0]   state_dbg
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        PULSE      = 3'd2,
        HELD       = 3'd3,
        REPEAT     = 3'd4,
        RELEASE_DB = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CNT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CNT - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);

    logic [N_BTN-1:0] dpb_v;
    logic [N_BTN-1:0] scen_v;
    logic [N_BTN-1:0] mcen_v;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic             s1, s2;
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             rep_d, scen_d, mcen_d, dpb_d;
        logic             dpb_q, scen_q, mcen_q;

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                s1      <= 1'b0;
                s2      <= 1'b0;
                state_q <= IDLE;
                cnt_q   <= '0;
                dpb_q   <= 1'b0;
                scen_q  <= 1'b0;
                mcen_q  <= 1'b0;
            end else begin
                s1      <= btn.PB_in[i];
                s2      <= s1;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                dpb_q   <= dpb_d;
                scen_q  <= scen_d;
                mcen_q  <= mcen_d;
            end
        end

        // A low sample always wins over an expiring hold/repeat count.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q + CNT_W'(1);
            rep_d   = 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (s2) state_d = PRESS_DB;
                end
                PRESS_DB: begin
                    if (!s2) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = PULSE;
                        cnt_d   = '0;
                    end
                end
                PULSE: begin
                    state_d = HELD;
                    cnt_d   = '0;
                end
                HELD: begin
                    if (!s2) begin
                        state_d = RELEASE_DB;
                        cnt_d   = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = REPEAT;
                        cnt_d   = '0;
                        rep_d   = 1'b1;
                    end
                end
                REPEAT: begin
                    if (!s2) begin
                        state_d = RELEASE_DB;
                        cnt_d   = '0;
                    end else if (cnt_q == REP_LAST) begin
                        cnt_d = '0;
                        rep_d = 1'b1;
                    end
                end
                RELEASE_DB: begin
                    if (s2) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign scen_d = (state_d == PULSE);
        assign mcen_d = scen_d | rep_d;
        assign dpb_d  = (state_d != IDLE) && (state_d != PRESS_DB);

        assign dpb_v[i]              = dpb_q;
        assign scen_v[i]             = scen_q;
        assign mcen_v[i]             = mcen_q;
        assign state_dbg[3*i +: 3]   = state_q;
    end

    assign btn.DPB  = dpb_v;
    assign btn.SCEN = scen_v;
    assign btn.MCEN = mcen_v;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button
// activity, all scored against a cycle-level reference of the button rules.
module tb_button_conditioner;

    localparam int N_BTN      = 6;
    localparam int DB_CNT     = 4;
    localparam int HOLD_CNT   = 10;
    localparam int REPEAT_CNT = 5;
    localparam int CNT_W      = 27;
    localparam int W          = 3 * N_BTN;

    logic               Clk   = 1'b0;
    logic               Reset = 1'b1;
    logic [3*N_BTN-1:0] state_dbg;

    button_conditioner_if #(.N_BTN(N_BTN)) btn_if ();

    button_conditioner #(
        .N_BTN     (N_BTN),
        .DB_CNT    (DB_CNT),
        .HOLD_CNT  (HOLD_CNT),
        .REPEAT_CNT(REPEAT_CNT),
        .CNT_W     (CNT_W)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .btn      (btn_if),
        .state_dbg(state_dbg)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [W-1:0] exp_q[$];

    // Reference: raw pipeline, accepted level, and run/age counters per button.
    logic [N_BTN-1:0] m_s1, m_s2, m_db, m_fresh;
    int m_run[N_BTN];
    int m_lo[N_BTN];
    int m_age[N_BTN];

    // Observation counters for the directed scenarios.
    int scen_cnt[N_BTN];
    int mcen_cnt[N_BTN];
    int dpb_cnt[N_BTN];
    int last_scen[N_BTN];
    int dpb_fall[N_BTN];
    logic [N_BTN-1:0] prev_dpb;
    int mcen_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_fresh = '0;
        for (int b = 0; b < N_BTN; b++) begin
            m_run[b] = 0; m_lo[b] = 0; m_age[b] = 0;
        end
    endtask

    task automatic model_edge(input logic [N_BTN-1:0] pb);
        logic [N_BTN-1:0] scen, mcen;
        logic s;
        scen = '0;
        mcen = '0;
        if (Reset) begin
            model_reset();
        end else begin
            for (int b = 0; b < N_BTN; b++) begin
                s = m_s2[b];
                if (!m_db[b]) begin
                    // Press accepted after DB_CNT+1 consecutive high samples.
                    m_run[b] = s ? m_run[b] + 1 : 0;
                    if (m_run[b] == DB_CNT + 1) begin
                        m_db[b] = 1'b1; m_run[b] = 0; m_fresh[b] = 1'b1;
                        scen[b] = 1'b1; mcen[b] = 1'b1;
                    end
                end else if (m_fresh[b]) begin
                    m_fresh[b] = 1'b0; m_age[b] = 0; m_lo[b] = 0;
                end else if (m_lo[b] > 0) begin
                    if (s) begin
                        m_lo[b] = 0; m_age[b] = 0;
                    end else begin
                        m_lo[b]++;
                        if (m_lo[b] == DB_CNT + 1) begin
                            m_db[b] = 1'b0; m_lo[b] = 0; m_run[b] = 0;
                        end
                    end
                end else if (!s) begin
                    m_lo[b] = 1;
                end else begin
                    if (m_age[b] >= HOLD_CNT - 1 &&
                        (m_age[b] - (HOLD_CNT - 1)) % REPEAT_CNT == 0)
                        mcen[b] = 1'b1;
                    m_age[b]++;
                end
            end
            m_s2 = m_s1;
            m_s1 = pb;
        end
        exp_q.push_back({m_db, scen, mcen});
    endtask

    task automatic clear_mon();
        for (int b = 0; b < N_BTN; b++) begin
            scen_cnt[b] = 0; mcen_cnt[b] = 0; dpb_cnt[b] = 0;
            last_scen[b] = -1; dpb_fall[b] = -1;
        end
        mcen_log.delete();
    endtask

    task automatic tick(input logic [N_BTN-1:0] pb);
        logic [W-1:0] e;
        btn_if.PB_in = pb;
        @(posedge Clk);
        cyc++;
        model_edge(pb);
        @(negedge Clk);
        e = exp_q.pop_front();
        check("dpb",  btn_if.DPB,  e[3*N_BTN-1:2*N_BTN]);
        check("scen", btn_if.SCEN, e[2*N_BTN-1:N_BTN]);
        check("mcen", btn_if.MCEN, e[N_BTN-1:0]);
        for (int b = 0; b < N_BTN; b++) begin
            if (btn_if.SCEN[b]) begin scen_cnt[b]++; last_scen[b] = cyc; end
            if (btn_if.MCEN[b]) begin
                mcen_cnt[b]++;
                if (b == 5) mcen_log.push_back(cyc);
            end
            if (btn_if.DPB[b]) dpb_cnt[b]++;
            if (prev_dpb[b] && !btn_if.DPB[b]) dpb_fall[b] = cyc;
        end
        prev_dpb = btn_if.DPB;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) tick('0);
    endtask

    initial begin
        int k, a, r, others;
        int exp_rep[6];
        logic [N_BTN-1:0] lvl;
        int hold_left[N_BTN];

        btn_if.PB_in = '0;
        prev_dpb = '0;
        model_reset();
        clear_mon();

        // Reset state
        tick('0);
        tick(6'b111111);
        Reset = 1'b0;
        idle(4);

        // Clean press on Select
        clear_mon();
        k = cyc + 1;
        for (int c = 0; c < 8; c++) tick(6'b000010);
        idle(12);
        check("clean_scen_cycle", last_scen[1], k + 6);
        check("clean_scen_count", scen_cnt[1], 1);
        check("clean_mcen_count", mcen_cnt[1], 1);
        check("clean_dpb_cycles", dpb_cnt[1], 8);
        others = 0;
        for (int b = 0; b < N_BTN; b++)
            if (b != 1) others += scen_cnt[b] + mcen_cnt[b] + dpb_cnt[b];
        check("clean_other_bits", others, 0);

        // Press bounce on Up
        clear_mon();
        tick(6'b000100); tick(6'b000100); tick(6'b000000);
        tick(6'b000100); tick(6'b000000);
        idle(12);
        check("bounce_activity", scen_cnt[2] + mcen_cnt[2] + dpb_cnt[2], 0);

        // Long hold on Right
        clear_mon();
        k = cyc + 1;
        for (int c = 0; c < 40; c++) tick(6'b100000);
        idle(12);
        exp_rep = '{6, 17, 22, 27, 32, 37};
        check("hold_mcen_count", mcen_log.size(), 6);
        for (int j = 0; j < 6; j++)
            if (j < mcen_log.size()) check("hold_mcen_cycle", mcen_log[j], k + exp_rep[j]);
        check("hold_scen_cycle", last_scen[5], k + 6);
        check("hold_scen_count", scen_cnt[5], 1);

        // Release bounce on Start
        clear_mon();
        for (int c = 0; c < 20; c++) tick(6'b000001);
        a = cyc + 1;
        tick('0); tick('0); tick(6'b000001);
        idle(14);
        check("relbounce_scen_count", scen_cnt[0], 1);
        check("relbounce_dpb_fall", dpb_fall[0], a + 9);

        // Simultaneous Down + Left
        clear_mon();
        k = cyc + 1;
        for (int c = 0; c < 8; c++) tick(6'b011000);
        idle(12);
        check("simul_scen3", last_scen[3], k + 6);
        check("simul_scen4", last_scen[4], k + 6);

        // Reset while repeating
        for (int c = 0; c < 22; c++) tick(6'b000001);
        Reset = 1'b1;
        #1;
        check("rst_dpb",  btn_if.DPB,  0);
        check("rst_scen", btn_if.SCEN, 0);
        check("rst_mcen", btn_if.MCEN, 0);
        tick(6'b000001); tick(6'b000001);
        Reset = 1'b0;
        clear_mon();
        r = cyc + 1;
        for (int c = 0; c < 10; c++) tick(6'b000001);
        idle(12);
        check("rst_fresh_scen_cycle", last_scen[0], r + 6);
        check("rst_fresh_scen_count", scen_cnt[0], 1);

        // Random activity with an occasional reset
        lvl = '0;
        for (int b = 0; b < N_BTN; b++) hold_left[b] = $urandom_range(1, 20);
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < N_BTN; b++) begin
                if (hold_left[b] == 0) begin
                    lvl[b] = ~lvl[b];
                    hold_left[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                               : $urandom_range(4, 45);
                end
                hold_left[b]--;
            end
            if (c == 2000) Reset = 1'b1;
            if (c == 2003) Reset = 1'b0;
            tick(lvl);
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
